mul_seq_ctrl: RTL and testbench



---
 rtl/mul_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// ============================================================================
// mul_seq_ctrl : sequences 32x32 Nios II-style multiplies (MUL/MULXUU/MULXSU/
//                MULXSS) over a shared registered 16x16 unsigned multiplier.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mul_seq_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_src1_i,
  input  logic [31:0] req_src2_i,
  input  logic        abort_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_result_o,
  output logic        mul_en_o,
  output logic [15:0] mul_a_o,
  output logic [15:0] mul_b_o,
  input  logic [31:0] mul_p_i
);

  localparam logic [1:0] c_op_mul    = 2'b00;
  localparam logic [1:0] c_op_mulxss = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_P0, S_P1, S_P2, S_P3, S_TAIL, S_FIX, S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [1:0]                op_q;
  logic [31:0]               a_q, b_q;
  logic [63:0]               acc_q;
  logic [31:0]               hi_q;
  logic [MUL_LAT-1:0]        vld_q;
  logic [MUL_LAT-1:0][1:0]   tag_q;

  logic        w_issue;
  logic [1:0]  w_tag;
  logic        w_abort;
  logic        w_is_mul;
  logic        w_last;
  logic [63:0] w_pp;
  logic [31:0] w_corr_a, w_corr_b;

  assign w_abort  = abort_i && (state_q != S_IDLE);
  assign w_is_mul = (op_q == c_op_mul);
  // Product tagged as the final partial product of this op is arriving now.
  assign w_last   = vld_q[MUL_LAT-1] &&
                    (tag_q[MUL_LAT-1] == (w_is_mul ? 2'd2 : 2'd3));
  // Signed high-word correction terms (op[1] marks a signed A operand).
  assign w_corr_a = (op_q[1] && a_q[31]) ? b_q : 32'd0;
  assign w_corr_b = ((op_q == c_op_mulxss) && b_q[31]) ? a_q : 32'd0;

  always_comb begin
    w_pp = {16'd0, mul_p_i, 16'd0};
    case (tag_q[MUL_LAT-1])
      2'd0:    w_pp = {32'd0, mul_p_i};
      2'd3:    w_pp = {mul_p_i, 32'd0};
      default: w_pp = {16'd0, mul_p_i, 16'd0};
    endcase
  end

  always_comb begin
    state_d       = state_q;
    w_issue       = 1'b0;
    w_tag         = 2'd0;
    mul_a_o       = 16'd0;
    mul_b_o       = 16'd0;
    req_ready_o   = (state_q == S_IDLE);
    resp_valid_o  = 1'b0;
    resp_result_o = 32'd0;
    case (state_q)
      S_IDLE: if (req_valid_i) state_d = S_P0;
      S_P0: begin
        w_issue = 1'b1; w_tag = 2'd0;
        mul_a_o = a_q[15:0];  mul_b_o = b_q[15:0];
        state_d = S_P1;
      end
      S_P1: begin
        w_issue = 1'b1; w_tag = 2'd1;
        mul_a_o = a_q[15:0];  mul_b_o = b_q[31:16];
        state_d = S_P2;
      end
      S_P2: begin
        w_issue = 1'b1; w_tag = 2'd2;
        mul_a_o = a_q[31:16]; mul_b_o = b_q[15:0];
        state_d = w_is_mul ? S_TAIL : S_P3;
      end
      S_P3: begin
        w_issue = 1'b1; w_tag = 2'd3;
        mul_a_o = a_q[31:16]; mul_b_o = b_q[31:16];
        state_d = S_TAIL;
      end
      S_TAIL: if (w_last) state_d = w_is_mul ? S_DONE : S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        resp_valid_o  = 1'b1;
        resp_result_o = w_is_mul ? acc_q[31:0] : hi_q;
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a completing handshake in DONE.
    if (w_abort) begin
      state_d       = S_IDLE;
      w_issue       = 1'b0;
      mul_a_o       = 16'd0;
      mul_b_o       = 16'd0;
      resp_valid_o  = 1'b0;
      resp_result_o = 32'd0;
    end
  end

  assign mul_en_o = w_issue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      vld_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && req_valid_i) begin
        op_q  <= req_op_i;
        a_q   <= req_src1_i;
        b_q   <= req_src2_i;
        acc_q <= 64'd0;
      end else if (vld_q[MUL_LAT-1] && !w_abort) begin
        acc_q <= acc_q + w_pp;
      end
      if ((state_q == S_FIX) && !w_abort)
        hi_q <= acc_q[63:32] - w_corr_a - w_corr_b;
      if (w_abort) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= w_issue;
        for (int i = 1; i < MUL_LAT; i++) vld_q[i] <= vld_q[i-1];
      end
      tag_q[0] <= w_tag;
      for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
// ============================================================================
// tb_mul_seq_ctrl : directed bench for mul_seq_ctrl, MUL_LAT=1 and MUL_LAT=2
//                   instances checked against a cycle-level behavioural model.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          fails  = 0;

  logic        req_valid   [2];
  logic        req_ready   [2];
  logic [1:0]  req_op      [2];
  logic [31:0] req_src1    [2];
  logic [31:0] req_src2    [2];
  logic        abort       [2];
  logic        resp_valid  [2];
  logic        resp_ready  [2];
  logic [31:0] resp_result [2];
  logic        mul_en      [2];
  logic [15:0] mul_a       [2];
  logic [15:0] mul_b       [2];
  logic [31:0] mul_p       [2];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Full-precision product of the (sign-)extended operands; pick the word.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = op[1] ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] ref_ab(input int n, input logic [31:0] a, input logic [31:0] b);
    case (n)
      1:       return {a[15:0],  b[15:0]};
      2:       return {a[15:0],  b[31:16]};
      3:       return {a[31:16], b[15:0]};
      default: return {a[31:16], b[31:16]};
    endcase
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_inst
    logic [31:0] p1, p2;
    bit          busy;
    int          n;
    logic [1:0]  mop;
    logic [31:0] ma, mb;

    mul_seq_ctrl #(.MUL_LAT(k + 1)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid_i  (req_valid[k]),
      .req_ready_o  (req_ready[k]),
      .req_op_i     (req_op[k]),
      .req_src1_i   (req_src1[k]),
      .req_src2_i   (req_src2[k]),
      .abort_i      (abort[k]),
      .resp_valid_o (resp_valid[k]),
      .resp_ready_i (resp_ready[k]),
      .resp_result_o(resp_result[k]),
      .mul_en_o     (mul_en[k]),
      .mul_a_o      (mul_a[k]),
      .mul_b_o      (mul_b[k]),
      .mul_p_i      (mul_p[k])
    );

    always @(posedge clk) begin
      p1 <= {16'd0, mul_a[k]} * {16'd0, mul_b[k]};
      p2 <= p1;
    end
    assign mul_p[k] = (k == 0) ? p1 : p2;

    // n = cycle index since acceptance (1 = first issue cycle).
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        busy = 1'b0;
      end else if (busy && abort[k]) begin
        busy = 1'b0;
      end else if (busy && (n >= ((mop == 2'b00) ? 5 : 7) + k) && resp_ready[k]) begin
        busy = 1'b0;
      end else if (busy) begin
        n++;
      end else if (req_valid[k]) begin
        busy = 1'b1; n = 1;
        mop = req_op[k]; ma = req_src1[k]; mb = req_src2[k];
      end
    end

    always @(negedge clk) begin
      int  iss, tot;
      bit  e_en, e_val;
      if (chk_en && !reset) begin
        iss   = (mop == 2'b00) ? 3 : 4;
        tot   = ((mop == 2'b00) ? 5 : 7) + k;
        e_en  = busy && (n >= 1) && (n <= iss) && !abort[k];
        e_val = busy && (n >= tot) && !abort[k];
        chk($sformatf("L%0d req_ready", k + 1), {31'd0, req_ready[k]}, {31'd0, !busy});
        chk($sformatf("L%0d mul_en", k + 1), {31'd0, mul_en[k]}, {31'd0, e_en});
        chk($sformatf("L%0d resp_valid", k + 1), {31'd0, resp_valid[k]}, {31'd0, e_val});
        chk($sformatf("L%0d mul_ab", k + 1), {mul_a[k], mul_b[k]},
            e_en ? ref_ab(n, ma, mb) : 32'd0);
        if (e_val)
          chk($sformatf("L%0d resp_result", k + 1), resp_result[k], ref_res(mop, ma, mb));
      end
    end
  end

  // Called one time unit after a rising edge with the DUT idle.
  task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int cyc;
    req_valid[k] = 1'b1; req_op[k] = op; req_src1[k] = a; req_src2[k] = b;
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    cyc = 1;
    while (!resp_valid[k] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("L%0d op%0d latency", k + 1, op), cyc, exp_lat);
    chk($sformatf("L%0d op%0d result", k + 1, op), resp_result[k], exp);
    @(posedge clk); #1;
  endtask

  task automatic backpressure(input int k);
    int          cyc;
    logic [31:0] held;
    req_valid[k] = 1'b1; req_op[k] = 2'b11;
    req_src1[k] = 32'h8000_0000; req_src2[k] = 32'h8000_0000;
    resp_ready[k] = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    while (!resp_valid[k] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("L%0d bp latency", k + 1), cyc, 7 + k);
    held = resp_result[k];
    chk($sformatf("L%0d bp result", k + 1), held, 32'h4000_0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("L%0d bp hold", k + 1), resp_result[k], held);
      chk($sformatf("L%0d bp ready", k + 1), {31'd0, req_ready[k]}, 32'd0);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("L%0d bp idle", k + 1), {31'd0, req_ready[k]}, 32'd1);
    chk($sformatf("L%0d bp mul_en idle", k + 1), {31'd0, mul_en[k]}, 32'd0);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    chk($sformatf("L%0d bp reissue", k + 1), {31'd0, mul_en[k]}, 32'd1);
    cyc = 1;
    while (!resp_valid[k] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("L%0d bp2 result", k + 1), resp_result[k], 32'h4000_0000);
    @(posedge clk); #1;
  endtask

  task automatic abort_test(input int k);
    req_valid[k] = 1'b1; req_op[k] = 2'b01;
    req_src1[k] = 32'hFFFF_FFFF; req_src2[k] = 32'hFFFF_FFFF;
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    abort[k] = 1'b1;
    #1 chk($sformatf("L%0d abort mul_en", k + 1), {31'd0, mul_en[k]}, 32'd0);
    @(posedge clk); #1;
    abort[k] = 1'b0;
    chk($sformatf("L%0d abort idle", k + 1), {31'd0, req_ready[k]}, 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
      chk($sformatf("L%0d abort no resp", k + 1), {31'd0, resp_valid[k]}, 32'd0);
    end
    run_op(k, 2'b00, 32'd7, 32'd9, 32'h0000_003F, 5 + k);
  endtask

  task automatic reset_test(input int k);
    req_valid[k] = 1'b1; req_op[k] = 2'b11;
    req_src1[k] = 32'hFFFF_FFFF; req_src2[k] = 32'h0000_0002;
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk($sformatf("L%0d P3 mul_en", k + 1), {31'd0, mul_en[k]}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk($sformatf("L%0d rst mul_en", k + 1), {31'd0, mul_en[k]}, 32'd0);
    chk($sformatf("L%0d rst resp_valid", k + 1), {31'd0, resp_valid[k]}, 32'd0);
    chk($sformatf("L%0d rst resp_result", k + 1), resp_result[k], 32'd0);
    chk($sformatf("L%0d rst req_ready", k + 1), {31'd0, req_ready[k]}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(k, 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 7 + k);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_op[k] = 2'b00; req_src1[k] = 32'd0; req_src2[k] = 32'd0;
      abort[k] = 1'b0; resp_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("L%0d reset req_ready", k + 1), {31'd0, req_ready[k]}, 32'd1);
      chk($sformatf("L%0d reset resp_valid", k + 1), {31'd0, resp_valid[k]}, 32'd0);
      chk($sformatf("L%0d reset mul_en", k + 1), {31'd0, mul_en[k]}, 32'd0);
      chk($sformatf("L%0d reset mul_ab", k + 1), {mul_a[k], mul_b[k]}, 32'd0);
      chk($sformatf("L%0d reset resp_result", k + 1), resp_result[k], 32'd0);
    end
    reset  = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run_op(k, 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 5 + k);
      run_op(k, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7 + k);
      run_op(k, 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 7 + k);
      run_op(k, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 7 + k);
      run_op(k, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7 + k);
      run_op(k, 2'b10, 32'h8000_0001, 32'h0000_0003, 32'hFFFF_FFFE, 7 + k);
      backpressure(k);
      abort_test(k);
      reset_test(k);
    end
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
